// File: rtl/conv_layer_sched_pkg.sv
// Shared encodings for the convolution unit's current_state bus.
package conv_layer_sched_pkg;

  localparam int CUR_STATE_W = 3;

  // Encodings the conv control logic decodes directly.
  localparam logic [CUR_STATE_W-1:0] CS_IDLE    = 3'd0;
  localparam logic [CUR_STATE_W-1:0] CS_LOAD_W  = 3'd1;
  localparam logic [CUR_STATE_W-1:0] CS_LOAD_B  = 3'd2;
  localparam logic [CUR_STATE_W-1:0] CS_RUN_3X3 = 3'd3;
  localparam logic [CUR_STATE_W-1:0] CS_RUN_PW  = 3'd4;
  localparam logic [CUR_STATE_W-1:0] CS_DRAIN   = 3'd5;
  localparam logic [CUR_STATE_W-1:0] CS_DONE    = 3'd6;

  typedef enum logic [CUR_STATE_W-1:0] {
    ST_IDLE    = CS_IDLE,
    ST_LOAD_W  = CS_LOAD_W,
    ST_LOAD_B  = CS_LOAD_B,
    ST_RUN_3X3 = CS_RUN_3X3,
    ST_RUN_PW  = CS_RUN_PW,
    ST_DRAIN   = CS_DRAIN,
    ST_DONE    = CS_DONE
  } state_t;

endpackage

// File: rtl/conv_layer_sched_if.sv
// Scheduler <-> parameter memory / conv unit handshake bundle.
interface conv_layer_sched_if;
  import conv_layer_sched_pkg::*;

  logic                   wt_req;
  logic                   wt_ack;
  logic                   bias_req;
  logic                   bias_ack;
  logic                   feed_en;
  logic                   conv_valid_out;
  logic                   state_rst;
  logic [CUR_STATE_W-1:0] current_state;

  // Scheduler side
  modport master (
    output wt_req, bias_req, feed_en, current_state,
    input  wt_ack, bias_ack, conv_valid_out, state_rst
  );

  // Memory / conv unit side
  modport slave (
    input  wt_req, bias_req, feed_en, current_state,
    output wt_ack, bias_ack, conv_valid_out, state_rst
  );
endinterface

// File: rtl/conv_layer_sched.sv
// Layer sequencer: per tile LOAD_W -> LOAD_B -> RUN -> DRAIN, then DONE.
module conv_layer_sched
  import conv_layer_sched_pkg::*;
#(
  parameter int PIX_CNT_WIDTH  = 20,
  parameter int TILE_CNT_WIDTH = 8,
  parameter int DRAIN_CYCLES   = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      cfg_pw_mode,
  input  logic [PIX_CNT_WIDTH-1:0]  cfg_out_pix,
  input  logic [TILE_CNT_WIDTH-1:0] cfg_tile_num,
  conv_layer_sched_if.master        cif,
  output logic [TILE_CNT_WIDTH-1:0] tile_idx,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0]             DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [DW-1:0]             DRAIN_ONE  = DW'(1);
  localparam logic [PIX_CNT_WIDTH-1:0]  PIX_ONE    = PIX_CNT_WIDTH'(1);
  localparam logic [TILE_CNT_WIDTH-1:0] TILE_ONE   = TILE_CNT_WIDTH'(1);

  state_t                      state_q, state_d;
  logic [PIX_CNT_WIDTH-1:0]    out_cnt_q;
  logic [DW-1:0]               drain_cnt_q;
  logic [TILE_CNT_WIDTH-1:0]   tile_idx_q;
  logic                        pw_q;
  logic [PIX_CNT_WIDTH-1:0]    pix_q;
  logic [TILE_CNT_WIDTH-1:0]   tiles_q;
  logic                        err_q;

  logic                        in_run;
  logic [PIX_CNT_WIDTH-1:0]    out_cnt_inc;
  logic                        last_beat;
  logic                        drain_end;
  logic [TILE_CNT_WIDTH-1:0]   tile_last;
  logic                        last_tile;
  logic                        start_ok;

  assign in_run      = (state_q == ST_RUN_3X3) || (state_q == ST_RUN_PW);
  assign out_cnt_inc = out_cnt_q + PIX_ONE;
  assign last_beat   = (out_cnt_inc == pix_q);
  // state_rst from the conv unit means the pipeline is already empty
  assign drain_end   = cif.state_rst || (drain_cnt_q == DRAIN_LAST);
  // a zero tile count runs a single tile
  assign tile_last   = (tiles_q == '0) ? '0 : tiles_q - TILE_ONE;
  assign last_tile   = (tile_idx_q == tile_last);
  assign start_ok    = (state_q == ST_IDLE) && start && !abort;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: abort overrides every transition
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:    if (start) state_d = ST_LOAD_W;
        ST_LOAD_W:  if (cif.wt_ack) state_d = ST_LOAD_B;
        ST_LOAD_B:  if (cif.bias_ack)
                      state_d = (pix_q == '0) ? ST_DRAIN :
                                (pw_q ? ST_RUN_PW : ST_RUN_3X3);
        ST_RUN_3X3,
        ST_RUN_PW:  if (cif.conv_valid_out && last_beat) state_d = ST_DRAIN;
        ST_DRAIN:   if (drain_end) state_d = last_tile ? ST_DONE : ST_LOAD_W;
        ST_DONE:    state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs decoded straight from the state register (no extra delay)
  always_comb begin
    cif.current_state = state_q;
    cif.wt_req        = (state_q == ST_LOAD_W);
    cif.bias_req      = (state_q == ST_LOAD_B);
    cif.feed_en       = in_run;
    busy              = (state_q != ST_IDLE) && (state_q != ST_DONE);
    done              = (state_q == ST_DONE);
    err               = err_q;
    tile_idx          = tile_idx_q;
  end

  // Config latch and beat / drain / tile counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_cnt_q   <= '0;
      drain_cnt_q <= '0;
      tile_idx_q  <= '0;
      pw_q        <= 1'b0;
      pix_q       <= '0;
      tiles_q     <= '0;
    end else if (abort) begin
      out_cnt_q   <= '0;
      drain_cnt_q <= '0;
      tile_idx_q  <= '0;
    end else begin
      if (start_ok) begin
        pw_q       <= cfg_pw_mode;
        pix_q      <= cfg_out_pix;
        tiles_q    <= cfg_tile_num;
        tile_idx_q <= '0;
      end
      // clearing in LOAD_B means every RUN entry starts from zero
      if (state_q == ST_LOAD_B)                out_cnt_q <= '0;
      else if (in_run && cif.conv_valid_out)   out_cnt_q <= out_cnt_inc;
      if (state_q == ST_DRAIN) drain_cnt_q <= drain_cnt_q + DRAIN_ONE;
      else                     drain_cnt_q <= '0;
      if ((state_q == ST_DRAIN) && drain_end && !last_tile)
        tile_idx_q <= tile_idx_q + TILE_ONE;
    end
  end

  // Sticky error: output beat outside RUN; a fresh layer start clears it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                            err_q <= 1'b0;
    else if (start_ok)                    err_q <= 1'b0;
    else if (cif.conv_valid_out && !in_run) err_q <= 1'b1;
  end

endmodule
